pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 16 +
 rtl/lu_hazard_detect.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared RV32I definitions and the state encoding used by the hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'b00,
    ST_WARMUP     = 2'b01,
    ST_RUN        = 2'b10
  } hz_state_e;

endpackage

// File: rtl/lu_hazard_detect.sv
// Load-use comparator: a load in EX feeds a source register read in ID.
module lu_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic     ex_is_load_i,
  input  reg_idx_t ex_rd_i,
  input  reg_idx_t id_rs1_i,
  input  reg_idx_t id_rs2_i,
  input  logic     id_rs1_used_i,
  input  logic     id_rs2_used_i,
  output logic     hazard_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_rs1_used_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit  = id_rs2_used_i && (id_rs2_i == ex_rd_i);
  // x0 is hardwired to zero, so a load into it never creates a dependency
  assign hazard_o = ex_is_load_i && (ex_rd_i != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: reset warm-up, ext stall, branch flush, load-use bubble.
//  state         | meaning
//  ST_RESET_HOLD | in or just out of reset; whole pipe held
//  ST_WARMUP     | stages released front to back, one per cycle
//  ST_RUN        | normal operation; stall/flush from live hazards
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NSTAGES     = 6,
  parameter int FLUSH_DEPTH = 3,
  parameter int LU_STAGE    = 2,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               branch_en_i,
  input  logic               ext_stall_i,
  input  logic               ex_is_load_i,
  input  reg_idx_t           ex_rd_i,
  input  reg_idx_t           id_rs1_i,
  input  reg_idx_t           id_rs2_i,
  input  logic               id_rs1_used_i,
  input  logic               id_rs2_used_i,
  output logic [NSTAGES-1:0] halt_o,
  output logic [NSTAGES-1:0] flush_o,
  output logic [1:0]         state_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  localparam int CW = $clog2(NSTAGES);
  localparam logic [CW-1:0] WARM_LAST = CW'(NSTAGES - 2);

  function automatic logic [NSTAGES-1:0] range_mask(input int lo, input int hi);
    logic [NSTAGES-1:0] m;
    for (int i = 0; i < NSTAGES; i++) begin
      m[i] = (i >= lo) && (i <= hi);
    end
    return m;
  endfunction

  function automatic logic [NSTAGES-1:0] warm_mask(input int k);
    return range_mask(k + 2, NSTAGES - 1);
  endfunction

  localparam logic [NSTAGES-1:0] BR_FLUSH = range_mask(1, FLUSH_DEPTH);
  localparam logic [NSTAGES-1:0] LU_HALT  = range_mask(0, LU_STAGE - 1);
  localparam logic [NSTAGES-1:0] LU_FLUSH = range_mask(LU_STAGE, LU_STAGE);

  hz_state_e          state_q, state_d;
  logic [CW-1:0]      wcnt_q, wcnt_d;
  logic [NSTAGES-1:0] warm_q, warm_d;
  logic               lu_seen_q, lu_seen_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               hazard;
  logic               lu_apply;

  lu_hazard_detect u_lu_hazard_detect (
    .ex_is_load_i  (ex_is_load_i),
    .ex_rd_i       (ex_rd_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .hazard_o      (hazard)
  );

  // lu_seen_q makes the bubble one-shot: the held inputs of a just-bubbled pair do not re-stall
  always_comb begin
    halt_o   = '0;
    flush_o  = '0;
    lu_apply = 1'b0;
    case (state_q)
      ST_RESET_HOLD: halt_o = '1;
      ST_WARMUP:     halt_o = ext_stall_i ? '1 : warm_q;
      ST_RUN: begin
        if (ext_stall_i) begin
          halt_o = '1;
        end else if (branch_en_i) begin
          flush_o = BR_FLUSH;
        end else if (hazard && !lu_seen_q) begin
          halt_o   = LU_HALT;
          flush_o  = LU_FLUSH;
          lu_apply = 1'b1;
        end
      end
      default:       halt_o = '1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    warm_d      = warm_q;
    lu_seen_d   = lu_apply;
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_RUN && halt_o[0] && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    case (state_q)
      ST_RESET_HOLD: begin
        state_d = ST_WARMUP;
        wcnt_d  = '0;
        warm_d  = warm_mask(0);
      end
      ST_WARMUP: begin
        if (!ext_stall_i) begin
          wcnt_d = wcnt_q + CW'(1);
          warm_d = warm_mask(int'(wcnt_d));
          if (wcnt_d == WARM_LAST) state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RESET_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RESET_HOLD;
      wcnt_q      <= '0;
      warm_q      <= '1;
      lu_seen_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      warm_q      <= warm_d;
      lu_seen_q   <= lu_seen_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (NSTAGES=6, FLUSH_DEPTH=3, LU_STAGE=2) plus a CNT_W=4 copy.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       branch_en, ext_stall, ex_is_load, rs1_used, rs2_used;
  logic [4:0] ex_rd, rs1, rs2;
  logic [5:0] halt, flush, halt4, flush4;
  logic [1:0] state, state4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NSTAGES(6), .FLUSH_DEPTH(3), .LU_STAGE(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .branch_en_i(branch_en), .ext_stall_i(ext_stall),
    .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .halt_o(halt), .flush_o(flush), .state_o(state), .stall_cnt_o(cnt)
  );

  pipe_hazard_ctrl #(.NSTAGES(6), .FLUSH_DEPTH(3), .LU_STAGE(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .branch_en_i(branch_en), .ext_stall_i(ext_stall),
    .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .halt_o(halt4), .flush_o(flush4), .state_o(state4), .stall_cnt_o(cnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    branch_en = 0; ext_stall = 0; ex_is_load = 0; rs1_used = 0; rs2_used = 0;
    ex_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] r2);
    ex_is_load = 1; ex_rd = rd; rs2 = r2; rs2_used = 1;
  endtask

  task automatic reset_to_run();
    @(negedge clk); idle(); rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    #1 check("rr_state", state, 32'd2);
    check("rr_cnt", cnt, 32'd0);
  endtask

  logic [5:0] warm_exp [5];
  logic [1:0] st_exp [5];

  initial begin
    warm_exp = '{6'b111100, 6'b111000, 6'b110000, 6'b100000, 6'b000000};
    st_exp   = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    idle();
    rst_n = 0;

    // reset release and warm-up walk
    repeat (3) @(negedge clk);
    #1 check("rst_halt", halt, 6'b111111);
    check("rst_flush", flush, 6'b0);
    check("rst_state", state, 2'b00);
    check("rst_cnt", cnt, 32'd0);
    rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check($sformatf("warm%0d_halt", k), halt, warm_exp[k]);
      check($sformatf("warm%0d_state", k), state, st_exp[k]);
    end

    // load-use via rs2
    @(negedge clk); set_lu(5'd5, 5'd5);
    #1 check("lu_halt", halt, 6'b000011);
    check("lu_flush", flush, 6'b000100);
    @(negedge clk); idle();
    #1 check("lu_end_halt", halt, 6'b0);
    check("lu_end_flush", flush, 6'b0);
    @(negedge clk); set_lu(5'd0, 5'd0);
    #1 check("lu_x0_halt", halt, 6'b0);
    check("lu_x0_flush", flush, 6'b0);
    // load-use via rs1, then rs1 match without its valid flag
    @(negedge clk); idle(); ex_is_load = 1; ex_rd = 7; rs1 = 7; rs1_used = 1;
    #1 check("lu_rs1_halt", halt, 6'b000011);
    check("lu_rs1_flush", flush, 6'b000100);
    @(negedge clk); idle();
    @(negedge clk); ex_is_load = 1; ex_rd = 7; rs1 = 7;
    #1 check("lu_unused_halt", halt, 6'b0);
    @(negedge clk); idle(); ex_rd = 9; rs2 = 9; rs2_used = 1;
    #1 check("noload_halt", halt, 6'b0);

    // branch with hazard, then back-to-back branch, then branch masked by ext_stall
    @(negedge clk); idle(); set_lu(5'd5, 5'd5); branch_en = 1;
    #1 check("br_lu_flush", flush, 6'b001110);
    check("br_lu_halt", halt, 6'b0);
    @(negedge clk); idle(); branch_en = 1;
    #1 check("br2_flush", flush, 6'b001110);
    check("br2_halt", halt, 6'b0);
    @(negedge clk); ext_stall = 1;
    #1 check("br_stall_halt", halt, 6'b111111);
    check("br_stall_flush", flush, 6'b0);
    @(negedge clk); idle();
    #1 check("cnt_after_run", cnt, 32'd3);

    // reset asserted mid warm-up, branch/hazard/ext_stall during warm-up
    reset_to_run();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    #1 check("rw_step0", halt, 6'b111100);
    @(negedge clk);
    #1 check("rw_step1", halt, 6'b111000);
    rst_n = 0; branch_en = 1;
    @(negedge clk);
    #1 check("rw_rst_halt", halt, 6'b111111);
    check("rw_rst_state", state, 2'b00);
    check("rw_rst_flush", flush, 6'b0);
    rst_n = 1;
    @(negedge clk);
    #1 check("rw2_halt0", halt, 6'b111100);
    check("rw2_br_ignored", flush, 6'b0);
    branch_en = 0;
    @(negedge clk); ext_stall = 1;
    #1 check("wu_stall_halt", halt, 6'b111111);
    check("wu_stall_state", state, 2'b01);
    @(negedge clk);
    #1 check("wu_stall_halt2", halt, 6'b111111);
    @(negedge clk); ext_stall = 0;
    #1 check("wu_resume", halt, 6'b111000);
    @(negedge clk); set_lu(5'd5, 5'd5); branch_en = 1;
    #1 check("wu_haz_halt", halt, 6'b110000);
    check("wu_haz_flush", flush, 6'b0);
    @(negedge clk); idle();
    #1 check("wu_last", halt, 6'b100000);
    @(negedge clk);
    #1 check("wu_run_state", state, 2'b10);
    check("wu_run_cnt", cnt, 32'd0);

    // ext_stall held over an active hazard, then exactly one bubble
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_lu(5'd5, 5'd5); ext_stall = 1;
      #1 check($sformatf("es%0d_halt", i), halt, 6'b111111);
      check($sformatf("es%0d_flush", i), flush, 6'b0);
    end
    @(negedge clk); ext_stall = 0;
    #1 check("es_lu_halt", halt, 6'b000011);
    check("es_lu_flush", flush, 6'b000100);
    @(negedge clk);
    #1 check("es_once_halt", halt, 6'b0);
    check("es_cnt", cnt, 32'd5);

    // saturation of the 4-bit counter copy
    reset_to_run();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); ext_stall = 1;
      #1;
      if (i == 14) check("sat_cnt14", cnt4, 32'd14);
      if (i == 15) check("sat_cnt15", cnt4, 32'd15);
    end
    @(negedge clk); ext_stall = 0;
    #1 check("sat_cnt4", cnt4, 32'd15);
    check("sat_cnt16", cnt, 32'd20);
    check("sat_halt", halt4, 6'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
